if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage with the IF/ID pipeline register. Holds the fetch PC,
//  issues fetches to instruction memory over a req/ready handshake, and forwards
//  PC4_F to the next-PC selector. It loads npc from that selector on every advance.
//  Captures the fetched word plus its PC/PC+4 into IF/ID for the decode stage.
//  A one-entry skid buffer holds a word that returns while decode is stalled.
// PARAMETERS
//  RESET_PC   32'h0000_3000  fetch PC loaded on reset
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  reset        in   1   asynchronous, active-high
//  npc          in   32  next PC from next-PC selector (PC+4 / branch / jump / jr)
//  stall        in   1   hazard-unit freeze of F and D (data hazards)
//  PC4_F        out  32  PC_F + 4, to next-PC selector
//  imem_req     out  1   fetch request valid
//  imem_addr    out  32  fetch address (= PC_F)
//  imem_rdata   in   32  fetched instruction, valid when imem_ready=1
//  imem_ready   in   1   fetch completes this cycle
//  fetch_busy   out  1   fetch outstanding and not completing; hazard unit freezes D, bubbles E
//  IR_D         out  32  instruction in decode
//  PC_D         out  32  PC of IR_D
//  PC4_D        out  32  PC_D + 4
//  valid_D      out  1   IR_D holds a real instruction
//  adel_D       out  1   misaligned fetch flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): PC_F=RESET_PC, state=FETCH, IR_D=0, PC_D=0, PC4_D=0, valid_D=0,
//   adel_D=0, skid empty. imem_req=0 while reset is high.
//  Combinational outputs: PC4_F=PC_F+32'd4 (mod 2^32); imem_addr=PC_F;
//   imem_req=(state==FETCH)&~reset; fetch_busy=(state==FETCH)&~imem_ready.
//  FSM states FETCH, HOLD:
//   FETCH, imem_ready=1, stall=0: advance.
//     IR_D<=imem_rdata, PC_D<=PC_F, PC4_D<=PC_F+4, valid_D<=1, PC_F<=npc. Stay FETCH.
//   FETCH, imem_ready=1, stall=1: skid<=imem_rdata, skid_pc<=PC_F; IF/ID and PC_F hold.
//     Go to HOLD.
//   FETCH, imem_ready=0: IF/ID and PC_F hold (branch stays in D until its delay slot
//     arrives), regardless of stall.
//   HOLD: imem_req=0. stall=1 -> hold all. stall=0 -> IF/ID<=skid/skid_pc
//     (PC4_D=skid_pc+4), valid_D<=1, PC_F<=npc. Go to FETCH.
//  Latency: with imem_ready tied 1 and no stall, a word at PC_F is in IR_D one cycle
//   later, giving one instruction per cycle. Branch delay slot is architectural:
//   no flush, and the slot is always fetched.
//  npc is sampled only on the advance edge. npc that is stable over held cycles is
//   not re-read.
//  Simultaneous stall deassert and imem_ready in FETCH: treated as a normal advance.
//  Reset mid-fetch abandons the outstanding request. Memory must tolerate req dropping.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined: on advance, if npc[1:0]!=2'b00, PC_F<=npc and the next
//   FETCH is suppressed (imem_req=0). On the next cycle with stall=0, IF/ID<=
//   {IR_D=0, PC_D=PC_F, PC4_D=PC_F+4, valid_D=1, adel_D=1}, then FETCH continues
//   at the new npc. adel_D clears on any normal advance.
//  PC_ALIGN_CHECK_EN undefined: no check, npc[1:0] ignored (fetch at PC_F), adel_D
//   tied 0.
// TESTING
//  1 reset, imem_ready=1, npc=PC4_F, 4 cycles -> PC_D 3000,3004,3008,300C; valid_D=1.
//  2 imem_ready low 3 cycles at PC_F=3008 -> fetch_busy=1 for 3 cycles; IR_D/PC_D
//    hold 3004; advance to 3008 on ready cycle.
//  3 ready=1 with stall=1 at 300C, rdata=0x2408_0005, stall 2 more cycles -> HOLD,
//    imem_req=0; stall drop -> IR_D=0x2408_0005, PC_D=300C.
//  4 jump: npc=0x0040_0000 on advance -> imem_addr=0x0040_0000 next cycle,
//    PC4_F=0x0040_0004.
//  5 wrap: npc=FFFF_FFFC -> PC4_F=0000_0000; PC4_D=0 after advance.
//  6 async reset asserted mid-HOLD -> immediate PC_F=3000, valid_D=0, imem_req=0;
//    [EN] npc=3002 -> adel_D=1, PC_D=3002, IR_D=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch with the IF/ID register and a one-entry skid buffer. Optional: PC_ALIGN_CHECK_EN.
// Latency: a word at PC_F reaches IR_D one cycle after imem_ready, giving one instruction per cycle.
// Backpressure: imem_ready=0 holds PC_F and IF/ID. A stall that lands on a completing fetch parks the word in skid (HOLD).
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    output logic [31:0] PC4_F,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        fetch_busy,
    output logic [31:0] IR_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC4_D,
    output logic        valid_D,
    output logic        adel_D
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        ADEL  = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc_f;
    logic [31:0] skid;
    logic [31:0] skid_pc;
    logic        advance;
    logic        skid_load;
    logic        skid_drain;
    logic        misalign;

`ifdef PC_ALIGN_CHECK_EN
    logic        adel_drain;
    assign misalign = (npc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
    assign adel_D   = 1'b0;
`endif

    assign PC4_F     = pc_f + 32'd4;
    assign imem_addr = pc_f;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // Every edge that loads npc into PC_F is where a misaligned target is caught.
    always_comb begin
        state_nx = state;
        case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (stall)         state_nx = HOLD;
                    else if (misalign) state_nx = ADEL;
                    else               state_nx = FETCH;
                end
            end
            HOLD: begin
                if (!stall) state_nx = misalign ? ADEL : FETCH;
            end
            ADEL: begin
                if (!stall) state_nx = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        fetch_busy = 1'b0;
        advance    = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        adel_drain = 1'b0;
`endif
        case (state)
            FETCH: begin
                imem_req   = ~reset;
                fetch_busy = ~imem_ready;
                advance    = imem_ready & ~stall;
                skid_load  = imem_ready & stall;
            end
            HOLD: begin
                skid_drain = ~stall;
            end
`ifdef PC_ALIGN_CHECK_EN
            ADEL: begin
                adel_drain = ~stall;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid    <= 32'd0;
            skid_pc <= 32'd0;
        end else if (skid_load) begin
            skid    <= imem_rdata;
            skid_pc <= pc_f;
        end
    end

    // npc is only consumed on the edges that move a word into decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f    <= RESET_PC;
            IR_D    <= 32'd0;
            PC_D    <= 32'd0;
            PC4_D   <= 32'd0;
            valid_D <= 1'b0;
        end else if (advance) begin
            pc_f    <= npc;
            IR_D    <= imem_rdata;
            PC_D    <= pc_f;
            PC4_D   <= pc_f + 32'd4;
            valid_D <= 1'b1;
        end else if (skid_drain) begin
            pc_f    <= npc;
            IR_D    <= skid;
            PC_D    <= skid_pc;
            PC4_D   <= skid_pc + 32'd4;
            valid_D <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        end else if (adel_drain) begin
            IR_D    <= 32'd0;
            PC_D    <= pc_f;
            PC4_D   <= pc_f + 32'd4;
            valid_D <= 1'b1;
`endif
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adel_D <= 1'b0;
        end else if (advance || skid_drain) begin
            adel_D <= 1'b0;
        end else if (adel_drain) begin
            adel_D <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, reset/skid corner sequences, then random traffic vs a queue model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic [31:0] PC4_F;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        fetch_busy;
    logic [31:0] IR_D;
    logic [31:0] PC_D;
    logic [31:0] PC4_D;
    logic        valid_D;
    logic        adel_D;

    if_stage dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .stall      (stall),
        .PC4_F      (PC4_F),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .fetch_busy (fetch_busy),
        .IR_D       (IR_D),
        .PC_D       (PC_D),
        .PC4_D      (PC4_D),
        .valid_D    (valid_D),
        .adel_D     (adel_D)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        ready;
        logic [31:0] npc;
        logic [31:0] rdata;
        logic [31:0] e_ir;
        logic [31:0] e_pcd;
        logic [31:0] e_pc4d;
        logic        e_valid;
        logic [31:0] e_addr;
        logic        e_req;
        logic        e_busy;
    } vec_t;

    vec_t tbl[15];

    // Behavioural reference: a word parked by a stall sits in a queue until decode frees up.
    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } skid_t;

    skid_t       mq[$];
    logic [31:0] mpc, mir, mpcd, mpc4d;
    logic        mvalid;

    task automatic model_reset();
        mq.delete();
        mpc    = 32'h0000_3000;
        mir    = 32'd0;
        mpcd   = 32'd0;
        mpc4d  = 32'd0;
        mvalid = 1'b0;
    endtask

    task automatic model_step();
        skid_t e;
        if (mq.size() != 0) begin
            if (!stall) begin
                e      = mq.pop_front();
                mir    = e.w;
                mpcd   = e.pc;
                mpc4d  = e.pc + 32'd4;
                mvalid = 1'b1;
                mpc    = npc;
            end
        end else if (imem_ready) begin
            if (!stall) begin
                mir    = imem_rdata;
                mpcd   = mpc;
                mpc4d  = mpc + 32'd4;
                mvalid = 1'b1;
                mpc    = npc;
            end else begin
                e.w  = imem_rdata;
                e.pc = mpc;
                mq.push_back(e);
            end
        end
    endtask

    initial begin
        logic [31:0] pc4;

        tbl[0]  = '{1'b0, 1'b1, 32'h0000_3004, 32'hA000_0000, 32'hA000_0000, 32'h0000_3000, 32'h0000_3004, 1'b1, 32'h0000_3004, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'h0000_3008, 32'hA100_0001, 32'hA100_0001, 32'h0000_3004, 32'h0000_3008, 1'b1, 32'h0000_3008, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0000_300C, 32'hDEAD_0002, 32'hA100_0001, 32'h0000_3004, 32'h0000_3008, 1'b1, 32'h0000_3008, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 32'h0000_300C, 32'hDEAD_0003, 32'hA100_0001, 32'h0000_3004, 32'h0000_3008, 1'b1, 32'h0000_3008, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 32'h0000_300C, 32'hDEAD_0004, 32'hA100_0001, 32'h0000_3004, 32'h0000_3008, 1'b1, 32'h0000_3008, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_300C, 32'hA200_0002, 32'hA200_0002, 32'h0000_3008, 32'h0000_300C, 1'b1, 32'h0000_300C, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'h0000_3010, 32'h2408_0005, 32'hA200_0002, 32'h0000_3008, 32'h0000_300C, 1'b1, 32'h0000_300C, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 32'h0000_3010, 32'hDEAD_BEEF, 32'hA200_0002, 32'h0000_3008, 32'h0000_300C, 1'b1, 32'h0000_300C, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0000_3010, 32'hDEAD_BEEF, 32'hA200_0002, 32'h0000_3008, 32'h0000_300C, 1'b1, 32'h0000_300C, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'h0000_3010, 32'hBAD0_0009, 32'h2408_0005, 32'h0000_300C, 32'h0000_3010, 1'b1, 32'h0000_3010, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h0040_0000, 32'hA300_0003, 32'hA300_0003, 32'h0000_3010, 32'h0000_3014, 1'b1, 32'h0040_0000, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hA400_0004, 32'hA400_0004, 32'h0040_0000, 32'h0040_0004, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 32'h0000_0000, 32'hA500_0005, 32'hA500_0005, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 32'h0000_0004, 32'hDEAD_000D, 32'hA500_0005, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 32'h0000_0004, 32'hA600_0006, 32'hA600_0006, 32'h0000_0000, 32'h0000_0004, 1'b1, 32'h0000_0004, 1'b1, 1'b0};

        reset      = 1'b1;
        stall      = 1'b0;
        imem_ready = 1'b1;
        npc        = 32'h0000_3004;
        imem_rdata = 32'd0;
        #1;
        chk("rst_addr",  imem_addr, 32'h0000_3000);
        chk("rst_pc4f",  PC4_F,     32'h0000_3004);
        chk("rst_req",   imem_req,  1'b0);
        chk("rst_valid", valid_D,   1'b0);
        chk("rst_ir",    IR_D,      32'd0);
        chk("rst_pcd",   PC_D,      32'd0);
        chk("rst_pc4d",  PC4_D,     32'd0);
        chk("rst_adel",  adel_D,    1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_req", imem_req, 1'b1);

        for (int i = 0; i < 15; i++) begin
            stall      = tbl[i].stall;
            imem_ready = tbl[i].ready;
            npc        = tbl[i].npc;
            imem_rdata = tbl[i].rdata;
            @(posedge clk);
            #1;
            pc4 = tbl[i].e_addr + 32'd4;
            chk($sformatf("v%0d_ir", i),    IR_D,       tbl[i].e_ir);
            chk($sformatf("v%0d_pcd", i),   PC_D,       tbl[i].e_pcd);
            chk($sformatf("v%0d_pc4d", i),  PC4_D,      tbl[i].e_pc4d);
            chk($sformatf("v%0d_valid", i), valid_D,    tbl[i].e_valid);
            chk($sformatf("v%0d_addr", i),  imem_addr,  tbl[i].e_addr);
            chk($sformatf("v%0d_pc4f", i),  PC4_F,      pc4);
            chk($sformatf("v%0d_req", i),   imem_req,   tbl[i].e_req);
            chk($sformatf("v%0d_busy", i),  fetch_busy, tbl[i].e_busy);
            chk($sformatf("v%0d_adel", i),  adel_D,     1'b0);
        end

        // Async reset landing while a skidded word is parked.
        stall      = 1'b1;
        imem_ready = 1'b1;
        npc        = 32'h0000_0008;
        imem_rdata = 32'hCAFE_0001;
        @(posedge clk);
        #1;
        chk("hold_req", imem_req, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_addr",  imem_addr, 32'h0000_3000);
        chk("arst_valid", valid_D,   1'b0);
        chk("arst_req",   imem_req,  1'b0);
        chk("arst_pcd",   PC_D,      32'd0);
        stall = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_rel_req", imem_req, 1'b1);

`ifdef PC_ALIGN_CHECK_EN
        npc        = 32'h0000_3002;
        imem_rdata = 32'h1111_1111;
        @(posedge clk);
        #1;
        chk("adel1_pcd",  PC_D,      32'h0000_3000);
        chk("adel1_addr", imem_addr, 32'h0000_3002);
        chk("adel1_req",  imem_req,  1'b0);
        chk("adel1_adel", adel_D,    1'b0);
        @(posedge clk);
        #1;
        chk("adel2_adel",  adel_D,  1'b1);
        chk("adel2_pcd",   PC_D,    32'h0000_3002);
        chk("adel2_ir",    IR_D,    32'd0);
        chk("adel2_pc4d",  PC4_D,   32'h0000_3006);
        chk("adel2_valid", valid_D, 1'b1);
        chk("adel2_req",   imem_req, 1'b1);
`endif

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        for (int c = 0; c < 3000; c++) begin
            stall      = ($urandom_range(0, 9) < 3);
            imem_ready = ($urandom_range(0, 9) < 7);
            imem_rdata = $urandom;
            if ($urandom_range(0, 7) == 0) npc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            else                           npc = mpc + 32'd4;
            @(posedge clk);
            #1;
            model_step();
            chk("rnd_ir",    IR_D,       mir);
            chk("rnd_pcd",   PC_D,       mpcd);
            chk("rnd_pc4d",  PC4_D,      mpc4d);
            chk("rnd_valid", valid_D,    mvalid);
            chk("rnd_addr",  imem_addr,  mpc);
            chk("rnd_req",   imem_req,   (mq.size() == 0) ? 1'b1 : 1'b0);
            chk("rnd_busy",  fetch_busy, ((mq.size() == 0) && !imem_ready) ? 1'b1 : 1'b0);
            chk("rnd_adel",  adel_D,     1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
